// File: rtl/exec_stage_unit.sv
// Execute-stage slice: modulo-NUM_STAGES stage counter, ALU operand steering, 32-bit ALU and
// EXE result register. Define ALU_MUL_EN to enable opcode 13 (low 32 bits of in0*in1).
module exec_stage_unit #(
    parameter int unsigned NUM_STAGES = 5,
    localparam int unsigned STAGE_W = $clog2(NUM_STAGES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         alu_operation,
    input  logic [31:0]        reg_value_0,
    input  logic [31:0]        reg_value_1,
    output logic [STAGE_W-1:0] current_stage,
    output logic               stage_last,
    output logic [31:0]        alu_out,
    output logic               illegal_op,
    output logic [31:0]        alu_result
);

    if (NUM_STAGES < 2 || NUM_STAGES > 16) begin : g_bad_num_stages
        $error("NUM_STAGES must be in 2..16");
    end

    typedef enum logic [4:0] {
        OpAdd   = 5'd0,
        OpSub   = 5'd1,
        OpAnd   = 5'd2,
        OpOr    = 5'd3,
        OpXor   = 5'd4,
        OpNot   = 5'd5,
        OpSll   = 5'd6,
        OpSrl   = 5'd7,
        OpSra   = 5'd8,
        OpSlt   = 5'd9,
        OpSltu  = 5'd10,
        OpEq    = 5'd11,
        OpPass0 = 5'd12,
        OpMul   = 5'd13
    } alu_op_e;

    localparam logic [STAGE_W-1:0] LastStage = STAGE_W'(NUM_STAGES - 1);

    // ------------------------------------------------------------------
    // Stage counter
    // ------------------------------------------------------------------
    logic [STAGE_W-1:0] stage_q, stage_d;

    always_comb begin
        stage_d = stage_q + STAGE_W'(1);
        if (stage_q == LastStage) begin
            stage_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign current_stage = stage_q;
    assign stage_last    = (stage_q == LastStage);

    // ------------------------------------------------------------------
    // Operand steering
    // ------------------------------------------------------------------
    logic        op_legal;
    logic        op_unary;
    alu_op_e     op_select;
    logic [31:0] in0;
    logic [31:0] in1;

    always_comb begin
        op_legal = 1'b0;
        op_unary = 1'b0;
        case (alu_operation)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4,
            5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: op_legal = 1'b1;
            5'd5, 5'd12: begin
                op_legal = 1'b1;
                op_unary = 1'b1;
            end
`ifdef ALU_MUL_EN
            5'd13: op_legal = 1'b1;
`endif
            default: op_legal = 1'b0;
        endcase

        op_select = op_legal ? alu_op_e'(alu_operation) : OpAdd;
        in0       = reg_value_0;
        in1       = op_unary ? 32'd0 : reg_value_1;
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [4:0]  shamt;
    logic [31:0] alu_raw;

    assign shamt = in1[4:0];

    always_comb begin
        alu_raw = 32'd0;
        case (op_select)
            OpAdd:   alu_raw = in0 + in1;
            OpSub:   alu_raw = in0 - in1;
            OpAnd:   alu_raw = in0 & in1;
            OpOr:    alu_raw = in0 | in1;
            OpXor:   alu_raw = in0 ^ in1;
            OpNot:   alu_raw = ~in0;
            OpSll:   alu_raw = in0 << shamt;
            OpSrl:   alu_raw = in0 >> shamt;
            OpSra:   alu_raw = $unsigned($signed(in0) >>> shamt);
            OpSlt:   alu_raw = {31'd0, $signed(in0) < $signed(in1)};
            OpSltu:  alu_raw = {31'd0, in0 < in1};
            OpEq:    alu_raw = {31'd0, in0 == in1};
            OpPass0: alu_raw = in0;
`ifdef ALU_MUL_EN
            OpMul:   alu_raw = in0 * in1;
`endif
            default: alu_raw = 32'd0;
        endcase
    end

    // Illegal codes were steered to ADD; force the visible result to zero.
    assign alu_out    = op_legal ? alu_raw : 32'd0;
    assign illegal_op = ~op_legal;

    // ------------------------------------------------------------------
    // EXE result register
    // ------------------------------------------------------------------
    logic [31:0] result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= 32'd0;
        end else begin
            result_q <= alu_out;
        end
    end

    assign alu_result = result_q;

endmodule

// File: tb/tb_exec_stage_unit.sv
// Scoreboard bench for exec_stage_unit: directed test-plan vectors followed by random traffic,
// checked against a plain-arithmetic reference model.
module tb_exec_stage_unit;

    localparam int unsigned N  = 5;
    localparam int unsigned SW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    alu_operation = '0;
    logic [31:0]   reg_value_0 = '0;
    logic [31:0]   reg_value_1 = '0;
    logic [SW-1:0] current_stage;
    logic          stage_last;
    logic [31:0]   alu_out;
    logic          illegal_op;
    logic [31:0]   alu_result;

    exec_stage_unit #(.NUM_STAGES(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_operation (alu_operation),
        .reg_value_0   (reg_value_0),
        .reg_value_1   (reg_value_1),
        .current_stage (current_stage),
        .stage_last    (stage_last),
        .alu_out       (alu_out),
        .illegal_op    (illegal_op),
        .alu_result    (alu_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] out;
        logic        ill;
        logic [31:0] res;
        int          stage;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   stage_m = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Reference ALU straight from the opcode table.
    function automatic void ref_alu(input int op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic ill);
        int sh;
        sh  = int'(b % 32);
        ill = 1'b0;
        case (op)
            0:  r = a + b;
            1:  r = a - b;
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = ~a;
            6:  r = a << sh;
            7:  r = a >> sh;
            8:  r = $unsigned($signed(a) >>> sh);
            9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            10: r = (a < b) ? 32'd1 : 32'd0;
            11: r = (a == b) ? 32'd1 : 32'd0;
            12: r = a;
`ifdef ALU_MUL_EN
            13: r = 32'(64'(a) * 64'(b));
`endif
            default: begin
                r   = 32'd0;
                ill = 1'b1;
            end
        endcase
    endfunction

    task automatic issue(input string name, input logic r, input int op,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        #1;
        rst           = r;
        alu_operation = 5'(op);
        reg_value_0   = a;
        reg_value_1   = b;
        ref_alu(op, a, b, e.out, e.ill);
        e.name  = name;
        e.res   = r ? 32'd0 : e.out;
        stage_m = r ? 0 : (stage_m + 1) % N;
        e.stage = stage_m;
        e.last  = (stage_m == N - 1);
        exp_q.push_back(e);
    endtask

    // Monitor: combinational outputs before the edge, registered outputs after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                chk({e.name, " alu_out"}, alu_out, e.out);
                chk({e.name, " illegal_op"}, {31'd0, illegal_op}, {31'd0, e.ill});
                @(posedge clk);
                #1;
                e = exp_q.pop_front();
                chk({e.name, " alu_result"}, alu_result, e.res);
                chk({e.name, " current_stage"}, 32'(current_stage), 32'(e.stage));
                chk({e.name, " stage_last"}, {31'd0, stage_last}, {31'd0, e.last});
            end
        end
    end

    initial begin
        int          op;
        logic [31:0] a, b;

        issue("reset0", 1'b1, 0, 32'd0, 32'd0);
        issue("reset1", 1'b1, 0, 32'd0, 32'd0);

        issue("add_wrap", 1'b0, 0, 32'hFFFF_FFFF, 32'd1);
        issue("sub", 1'b0, 1, 32'd5, 32'd7);
        issue("and", 1'b0, 2, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        issue("or", 1'b0, 3, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        issue("xor", 1'b0, 4, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        issue("sll", 1'b0, 6, 32'd1, 32'h0000_0021);
        issue("srl", 1'b0, 7, 32'h8000_0000, 32'd31);
        issue("sra", 1'b0, 8, 32'h8000_0000, 32'd4);
        issue("slt", 1'b0, 9, 32'hFFFF_FFFF, 32'd1);
        issue("sltu", 1'b0, 10, 32'hFFFF_FFFF, 32'd1);
        issue("eq", 1'b0, 11, 32'h1234, 32'h1234);
        issue("not", 1'b0, 5, 32'd0, 32'h5555_5555);
        issue("pass0", 1'b0, 12, 32'hDEAD_BEEF, 32'h1111_1111);
        issue("illegal20", 1'b0, 20, 32'h1234_5678, 32'd9);
        issue("mul13", 1'b0, 13, 32'h0001_0000, 32'h0001_0001);

        // Pulse reset while the counter shows 3.
        while (stage_m != 3) issue("to_stage3", 1'b0, 0, 32'd1, 32'd2);
        issue("rst_at3", 1'b1, 0, 32'd3, 32'd4);
        issue("after_rst", 1'b0, 0, 32'd3, 32'd4);

        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                             : int'($urandom_range(0, 13));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = a;
                1: a = 32'hFFFF_FFFF;
                2: b = 32'(b[5:0]);
                default: ;
            endcase
            issue("random", ($urandom_range(0, 19) == 0), op, a, b);
        end

        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_stage_unit.md
Name: exec_stage_unit

Overview:
- Execute-stage datapath slice for the multicycle/pipelined CPU.
- Contains three parts:
  - a modulo-N stage counter that sequences instruction stages;
  - ALU operand/opcode steering (alu_control function);
  - a 32-bit combinational ALU whose output is captured in a result pipeline register every cycle.
- Sits between the register-file read pipeline registers and the memory-stage result mux.

Parameters:
- NUM_STAGES, 5, stage counter modulus; legal range 2..16.
- STAGE_W, $clog2(NUM_STAGES), width of the stage output; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- alu_operation  in  5  decoded ALU opcode from the instruction
- reg_value_0  in  32  operand A, from the register-file pipeline register
- reg_value_1  in  32  operand B, from the register-file pipeline register
- current_stage  out  STAGE_W  stage counter value
- stage_last  out  1  high while current_stage == NUM_STAGES-1
- alu_out  out  32  combinational ALU result
- illegal_op  out  1  combinational; high for an unsupported opcode
- alu_result  out  32  registered ALU result (EXE pipeline register)

Behaviour:
- Reset: on a rising clk edge with rst=1:
  - current_stage <= 0;
  - alu_result <= 0.
  - Combinational outputs follow their inputs regardless of rst.
- Stage counter:
  - Increments by 1 every clock when rst=0; no enable input.
  - NUM_STAGES-1 wraps to 0 on the next edge.
  - stage_last is decoded combinationally from the count.
  - rst asserted mid-sequence forces 0 on that edge; counting resumes from 0 on the first edge after rst deasserts.
- Operand steering (alu_control):
  - in0 = reg_value_0 and in1 = reg_value_1 for binary ops.
  - For unary ops (NOT, PASS0), in1 is forced to 0.
  - op_select = alu_operation for legal codes, ADD otherwise.
- ALU opcodes (decimal). All arithmetic is modulo 2^32, with no carry/overflow outputs.
  - 0 ADD: in0 + in1.
  - 1 SUB: in0 - in1.
  - 2 AND, 3 OR, 4 XOR: bitwise.
  - 5 NOT: ~in0.
  - 6 SLL: in0 << in1[4:0].
  - 7 SRL: logical right shift by in1[4:0].
  - 8 SRA: arithmetic right shift by in1[4:0].
  - Shift amounts use only in1[4:0]; upper bits are ignored.
  - 9 SLT: 1 if in0 < in1 as signed, else 0; zero-extended to 32 bits.
  - 10 SLTU: 1 if in0 < in1 as unsigned, else 0; zero-extended to 32 bits.
  - 11 EQ: 1 if in0 == in1, else 0; zero-extended to 32 bits.
  - 12 PASS0: in0.
  - 13 MUL: low 32 bits of in0*in1; only when the optional feature is enabled.
  - 14..31: illegal; alu_out = 0 and illegal_op = 1.
- Result register:
  - alu_result <= alu_out on every rising edge with rst=0.
  - Latency from operands/opcode to alu_result is exactly 1 cycle.
  - Holds 0 while rst=1.
- No handshake; purely streaming. A new operation may be issued every cycle.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: opcode 13 computes the low 32 bits of the unsigned product, combinational, same 1-cycle latency to alu_result; illegal_op = 0 for opcode 13.
- Undefined: no multiplier is synthesized; opcode 13 behaves as illegal (alu_out = 0, illegal_op = 1).

Test Plan:
- Counter wrap:
  - Stimulus: rst=1 for 2 cycles, then release, then 12 cycles.
  - Required: current_stage sequence 0,1,2,3,4,0,1,…; stage_last high only at 4.
  - Stimulus: rst pulsed at count 3.
  - Required: next value 0.
- Arithmetic:
  - ADD 0xFFFFFFFF+1 -> alu_out 0, alu_result 0 one cycle later.
  - SUB 5-7 -> 0xFFFFFFFE.
  - AND/OR/XOR of 0xF0F0F0F0 and 0x0FF00FF0 -> 0x00F000F0 / 0xFFF0FFF0 / 0xFF00FF00.
- Shifts:
  - SLL 1 by in1=0x00000021 -> 2 (only [4:0]=1 used).
  - SRL 0x80000000 by 31 -> 1.
  - SRA 0x80000000 by 4 -> 0xF8000000.
- Compare:
  - SLT 0xFFFFFFFF vs 1 -> 1.
  - SLTU same operands -> 0.
  - EQ 0x1234 vs 0x1234 -> 1.
  - NOT 0 -> 0xFFFFFFFF.
  - PASS0 0xDEADBEEF -> 0xDEADBEEF.
- Illegal/MUL:
  - Opcode 20 -> alu_out 0, illegal_op 1.
  - Opcode 13, 0x10000 * 0x10001:
    - with ALU_MUL_EN -> 0x00010000, illegal_op 0;
    - without -> 0, illegal_op 1.
- Reset on result:
  - Issue ADD 3+4 with rst=1 on the same edge -> alu_result stays 0.
  - Next edge with rst=0 -> alu_result 7.
